phase_decoder: RTL

//  Receive-side monitor for the four-wire stepper phase bus (a1,a2,b1,b2)

---
 rtl/phase_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/phase_decoder.sv
// phase_decoder: receive-side monitor for the four-wire stepper phase bus.
// Define HALF_STEP_EN to decode the 8-code half-step ring instead of the 4-code full-step ring.
module phase_decoder #(
  parameter int POS_W     = 16,
  parameter int STALL_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a1,
  input  logic             a2,
  input  logic             b1,
  input  logic             b2,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             stalled
);

  localparam int CNT_W = $clog2(STALL_CYC + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYC);
`ifdef HALF_STEP_EN
  localparam int RING = 8;
`else
  localparam int RING = 4;
`endif

  // Handshake: none. The phase bus is level-sampled every clock; step is a
  // single-cycle strobe with pos/dir already valid in the same cycle.

  logic [3:0]       ph_q;
  logic             last_vld;
  logic [2:0]       last_idx;
  logic [CNT_W-1:0] stall_cnt;

  logic             legal;
  logic [2:0]       idx;
  logic [2:0]       fwd_idx;
  logic [2:0]       rev_idx;

  logic             last_vld_n;
  logic [2:0]       last_idx_n;
  logic [POS_W-1:0] pos_n;
  logic             dir_n;
  logic             step_n;
  logic             err_n;
  logic             err_set;
  logic [CNT_W-1:0] stall_cnt_n;
  logic             stalled_n;

  // Map the registered phase code to its position in the ring.
  always_comb begin
    legal = 1'b1;
    idx   = 3'd0;
    case (ph_q)
`ifdef HALF_STEP_EN
      4'b1000: idx = 3'd0;
      4'b1010: idx = 3'd1;
      4'b0010: idx = 3'd2;
      4'b0110: idx = 3'd3;
      4'b0100: idx = 3'd4;
      4'b0101: idx = 3'd5;
      4'b0001: idx = 3'd6;
      4'b1001: idx = 3'd7;
`else
      4'b1000: idx = 3'd0;
      4'b0010: idx = 3'd1;
      4'b0100: idx = 3'd2;
      4'b0001: idx = 3'd3;
`endif
      default: legal = 1'b0;
    endcase
    fwd_idx = (last_idx == 3'(RING - 1)) ? 3'd0 : last_idx + 3'd1;
    rev_idx = (last_idx == 3'd0) ? 3'(RING - 1) : last_idx - 3'd1;
  end

  always_comb begin
    last_vld_n = last_vld;
    last_idx_n = last_idx;
    pos_n      = pos;
    dir_n      = dir;
    step_n     = 1'b0;
    err_set    = 1'b0;
    if (ph_q == 4'b0000) begin
      err_set = 1'b0;
    end else if (!legal) begin
      err_set = 1'b1;
    end else if (!last_vld) begin
      last_vld_n = 1'b1;
      last_idx_n = idx;
    end else if (idx == last_idx) begin
      err_set = 1'b0;
    end else if (idx == fwd_idx) begin
      pos_n      = pos + POS_W'(1);
      dir_n      = 1'b1;
      step_n     = 1'b1;
      last_idx_n = idx;
    end else if (idx == rev_idx) begin
      pos_n      = pos - POS_W'(1);
      dir_n      = 1'b0;
      step_n     = 1'b1;
      last_idx_n = idx;
    end else begin
      // Jump across the ring: flag it and resynchronise on the new code.
      err_set    = 1'b1;
      last_idx_n = idx;
    end

    if (step_n)
      stall_cnt_n = '0;
    else if (stall_cnt == STALL_MAX)
      stall_cnt_n = stall_cnt;
    else
      stall_cnt_n = stall_cnt + CNT_W'(1);

    // Clear wins over position and error, but step/dir/last still follow the bus.
    if (clr) begin
      pos_n       = '0;
      stall_cnt_n = '0;
    end
    err_n     = !clr && (err || err_set);
    stalled_n = (stall_cnt_n == STALL_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q      <= 4'b0000;
      last_vld  <= 1'b0;
      last_idx  <= 3'd0;
      pos       <= '0;
      dir       <= 1'b0;
      step      <= 1'b0;
      err       <= 1'b0;
      stall_cnt <= '0;
      stalled   <= 1'b0;
    end else begin
      ph_q      <= {a1, a2, b1, b2};
      last_vld  <= last_vld_n;
      last_idx  <= last_idx_n;
      pos       <= pos_n;
      dir       <= dir_n;
      step      <= step_n;
      err       <= err_n;
      stall_cnt <= stall_cnt_n;
      stalled   <= stalled_n;
    end
  end

endmodule
